// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 7-segment display blocks
//   state_t   : sequencer phase (IDLE, SHOW, BLANK)
//   SEG_BLANK : all segments off
//   SEG_HEX   : active-high hex glyphs, bit0=a .. bit6=g, indexed by digit value
package seg_pkg;
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
endpackage

// File: rtl/hex7seg_decode.sv
// hex7seg_decode: combinational 4-bit hex digit to 7-segment glyph
//   digit : hex value 0..F
//   seg   : active-high segments, bit0=a .. bit6=g
module hex7seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    assign seg = SEG_HEX[digit];
endmodule

// File: rtl/seg_msg_sequencer.sv
// seg_msg_sequencer: buffers a short hex message and plays it digit by digit with hold/blank timing
//   clk, rst            : clock, asynchronous active-high reset
//   ena                 : enable; low freezes state, timer and buffer and blocks writes
//   wr_valid/wr_data    : append one hex digit; wr_ready high when it is accepted
//   start/loop/clr      : begin playback (loop sampled at start), clear buffer / abort
//   busy/done           : playback in progress / one-cycle end-of-message pulse
//   digit_idx           : buffer index of the digit being played
//   segments/dp         : active-high segment drive and decimal point
//   DP_HEARTBEAT_EN     : when defined, dp blinks while idle and marks the last digit in SHOW
module seg_msg_sequencer #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 10000000,
    parameter int GAP_CYCLES  = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     wr_valid,
    input  logic [3:0]               wr_data,
    output logic                     wr_ready,
    input  logic                     start,
    input  logic                     loop,
    input  logic                     clr,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] digit_idx,
    output logic [6:0]               segments,
    output logic                     dp
);
    import seg_pkg::*;

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t          state, next;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   timer;
    logic            loop_q, done_q;
    logic [3:0]      mem [DEPTH];
    logic [6:0]      dec_seg;
    logic            hold_end, gap_end, seg_end, last, start_ok;

    hex7seg_decode u_dec (
        .digit (mem[rd_ptr]),
        .seg   (dec_seg)
    );

    assign hold_end = (state == SHOW) && (timer == TW'(HOLD_CYCLES - 1));
    assign gap_end  = (state == BLANK) && (timer == TW'(GAP_CYCLES - 1));
    // A digit slot ends after its blank phase, or straight after hold when there is no blank.
    assign seg_end  = (GAP_CYCLES == 0) ? hold_end : gap_end;
    assign last     = CW'(rd_ptr) == count - 1'b1;
    assign start_ok = start && (count != '0) && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else if (ena)
            state <= next;
    end

    always_comb begin
        next = clr ? IDLE :
               (state == IDLE) ? (start_ok ? SHOW : IDLE) :
               seg_end ? ((last && !loop_q) ? IDLE : SHOW) :
               hold_end ? BLANK : state;
    end

`ifdef DP_HEARTBEAT_EN
    logic hb_q, hb_wrap;
    // The phase timer is otherwise idle in IDLE, so it doubles as the heartbeat divider.
    assign hb_wrap = timer == TW'(HOLD_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hb_q <= 1'b0;
        else if (ena && state == IDLE && hb_wrap && !start_ok)
            hb_q <= ~hb_q;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            timer  <= '0;
            loop_q <= 1'b0;
            done_q <= 1'b0;
        end else if (ena) begin
            done_q <= !clr && seg_end && last && !loop_q;
            if (state == IDLE) begin
                count <= clr ? '0 : (wr_valid && wr_ready) ? count + 1'b1 : count;
                if (start_ok) begin
                    loop_q <= loop;
                    rd_ptr <= '0;
                end
`ifdef DP_HEARTBEAT_EN
                timer <= (start_ok || hb_wrap) ? '0 : timer + 1'b1;
`else
                timer <= '0;
`endif
            end else begin
                rd_ptr <= (!clr && seg_end) ? (last ? '0 : rd_ptr + 1'b1) : rd_ptr;
                timer  <= (clr || seg_end || hold_end) ? '0 : timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_valid && wr_ready)
            mem[count[AW-1:0]] <= wr_data;
    end

    always_comb begin
        busy      = state != IDLE;
        done      = done_q;
        wr_ready  = ena && (state == IDLE) && (count < CW'(DEPTH)) && !clr;
        digit_idx = (state != IDLE) ? rd_ptr : '0;
        segments  = (state == SHOW) ? dec_seg : SEG_BLANK;
`ifdef DP_HEARTBEAT_EN
        dp        = (state == IDLE) ? hb_q : (state == SHOW) && last;
`else
        dp        = 1'b0;
`endif
    end
endmodule
